// File: rtl/oci_dct_pkg.sv
// Shared definitions for the OCI debug-capture-trace sequencer: frame/word geometry,
// output widths and the capture state enum.
package oci_dct_pkg;

  localparam int FRAME_W         = 10;
  localparam int FRAMES_PER_WORD = 3;
  localparam int BUF_W           = FRAME_W * FRAMES_PER_WORD;
  localparam int COUNT_W         = 4;
  localparam int WORDS_W         = 5;
  localparam int DROP_W          = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DONE    = 3'd4
  } dct_state_e;

endpackage

// File: rtl/oci_dct_packer.sv
// Packs trace frames into the output word and runs the valid/ready handoff to the drain.
// The sequencer above decides which mode (capture, flush, clear) applies each cycle.
module oci_dct_packer
  import oci_dct_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear_i,
  input  logic               capture_i,
  input  logic               flush_i,
  input  logic               last_word_i,
  input  logic               frame_valid_i,
  input  logic [FRAME_W-1:0] frame_data_i,
  input  logic               out_ready_i,
  output logic [BUF_W-1:0]   dct_buffer_o,
  output logic [COUNT_W-1:0] dct_count_o,
  output logic               out_valid_o,
  output logic               handshake_o,
  output logic               frame_taken_o
);

  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               vld_q, vld_d;

  assign handshake_o = vld_q & out_ready_i;

  always_comb begin
    buf_d         = buf_q;
    cnt_d         = cnt_q;
    vld_d         = vld_q;
    frame_taken_o = 1'b0;
    if (clear_i) begin
      buf_d = '0;
      cnt_d = '0;
      vld_d = 1'b0;
    end else if (capture_i) begin
      if (vld_q) begin
        // A completed word frees the buffer; a same-cycle frame restarts it unless this was the last word.
        if (out_ready_i) begin
          buf_d = '0;
          cnt_d = '0;
          vld_d = 1'b0;
          if (frame_valid_i && !last_word_i) begin
            buf_d[FRAME_W-1:0] = frame_data_i;
            cnt_d              = COUNT_W'(1);
            frame_taken_o      = 1'b1;
          end
        end
      end else if (frame_valid_i) begin
        for (int i = 0; i < FRAMES_PER_WORD; i++) begin
          if (cnt_q == COUNT_W'(i)) begin
            buf_d[i*FRAME_W +: FRAME_W] = frame_data_i;
          end
        end
        cnt_d         = cnt_q + COUNT_W'(1);
        vld_d         = (cnt_q == COUNT_W'(FRAMES_PER_WORD - 1));
        frame_taken_o = 1'b1;
      end
    end else if (flush_i) begin
      if (vld_q) begin
        if (out_ready_i) begin
          buf_d = '0;
          cnt_d = '0;
          vld_d = 1'b0;
        end
      end else if (cnt_q != '0) begin
        vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  assign dct_buffer_o = buf_q;
  assign dct_count_o  = cnt_q;
  assign out_valid_o  = vld_q;

endmodule

// File: rtl/oci_dct_sequencer.sv
// OCI debug-capture-trace sequencer: arm/start/stop FSM, capture counters and end-of-test
// flags around the frame packer.
module oci_dct_sequencer
  import oci_dct_pkg::*;
#(
  parameter int MAX_WORDS = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               arm,
  input  logic               disarm,
  input  logic               trig_start,
  input  logic               trig_stop,
  input  logic               frame_valid,
  input  logic [FRAME_W-1:0] frame_data,
  output logic [BUF_W-1:0]   dct_buffer,
  output logic [COUNT_W-1:0] dct_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORDS_W-1:0] words_sent,
  output logic [DROP_W-1:0]  drop_cnt,
  output logic               test_ending,
  output logic               test_has_ended
);

  dct_state_e         state_q, state_d;
  logic [WORDS_W-1:0] words_sent_q, words_sent_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic               test_ending_q, test_has_ended_q;

  logic arm_ok, last_word, active;
  logic pk_clear, pk_capture, pk_flush, pk_handshake, pk_taken;
  logic hs_count, drop_event;

  assign arm_ok    = !disarm && arm && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_word = ((words_sent_q + WORDS_W'(1)) == WORDS_W'(MAX_WORDS));
  assign active    = (state_q == ST_CAPTURE) || (state_q == ST_FLUSH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (disarm) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: if (arm) state_d = ST_ARMED;
        ST_ARMED:         if (trig_start) state_d = ST_CAPTURE;
        ST_CAPTURE: begin
          // Reaching the word limit ends the capture even if a stop arrives in the same cycle.
          if (pk_handshake && last_word) state_d = ST_DONE;
          else if (trig_stop)            state_d = ST_FLUSH;
        end
        ST_FLUSH: begin
          if (pk_handshake || (!out_valid && (dct_count == '0))) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pk_clear   = disarm || arm_ok;
    pk_capture = !disarm && ((state_q == ST_CAPTURE) || ((state_q == ST_ARMED) && trig_start));
    pk_flush   = !disarm && (state_q == ST_FLUSH);
    hs_count   = !disarm && active && pk_handshake;
    drop_event = !disarm && active && frame_valid && !pk_taken;
  end

  always_comb begin
    words_sent_d = words_sent_q;
    drop_d       = drop_q;
    if (arm_ok) begin
      words_sent_d = '0;
      drop_d       = '0;
    end else begin
      if (hs_count)                     words_sent_d = words_sent_q + WORDS_W'(1);
      if (drop_event && (drop_q != '1)) drop_d       = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      words_sent_q     <= '0;
      drop_q           <= '0;
      test_ending_q    <= 1'b0;
      test_has_ended_q <= 1'b0;
    end else begin
      words_sent_q     <= words_sent_d;
      drop_q           <= drop_d;
      test_ending_q    <= (state_d == ST_FLUSH);
      test_has_ended_q <= (state_d == ST_DONE);
    end
  end

  oci_dct_packer u_packer (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear_i      (pk_clear),
    .capture_i    (pk_capture),
    .flush_i      (pk_flush),
    .last_word_i  (last_word),
    .frame_valid_i(frame_valid),
    .frame_data_i (frame_data),
    .out_ready_i  (out_ready),
    .dct_buffer_o (dct_buffer),
    .dct_count_o  (dct_count),
    .out_valid_o  (out_valid),
    .handshake_o  (pk_handshake),
    .frame_taken_o(pk_taken)
  );

  assign words_sent     = words_sent_q;
  assign drop_cnt       = drop_q;
  assign test_ending    = test_ending_q;
  assign test_has_ended = test_has_ended_q;

endmodule

// File: doc/oci_dct_sequencer.md
# oci_dct_sequencer

Capture sequencer for the OCI debug-capture-trace (DCT) path of the Nios II debug module. Arms on request, waits for a start trigger, packs 10-bit trace frames three-per-word into the 30-bit `dct_buffer`, and hands completed words to the JTAG drain over a valid/ready handshake. It flushes a partial word on stop and raises the end-of-test flags consumed by the OCI test bench.

## Interface
- `FRAME_W`, 10: trace frame width.
- `FRAMES_PER_WORD`, 3: frames packed per output word; `dct_buffer` width = `FRAME_W*FRAMES_PER_WORD` = 30.
- `MAX_WORDS`, 16: words accepted per capture before automatic end; range 1..31.
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `arm`  in  1: request to arm; honoured in IDLE and DONE.
- `disarm`  in  1: abort from any state to IDLE; highest priority.
- `trig_start`  in  1: start capture; honoured in ARMED only.
- `trig_stop`  in  1: stop capture; honoured in CAPTURE only.
- `frame_valid`  in  1: trace frame present this cycle.
- `frame_data`  in  10: trace frame.
- `dct_buffer`  out  30: packed word; slot i at bits [10i+9:10i]; unfilled slots are zero.
- `dct_count`  out  4: frames currently held in `dct_buffer` (0..3).
- `out_valid`  out  1: `dct_buffer` holds a word for the drain.
- `out_ready`  in  1: drain accepts the word when high with `out_valid`.
- `words_sent`  out  5: handshakes completed in the current capture.
- `drop_cnt`  out  8: frames dropped, saturating at 255.
- `test_ending`  out  1: high throughout FLUSH.
- `test_has_ended`  out  1: high throughout DONE.

## Operation
- States: IDLE, ARMED, CAPTURE, FLUSH, DONE.
- Reset: state IDLE. Every output is 0: `dct_buffer`, `dct_count`, `out_valid`, `words_sent`, `drop_cnt`, `test_ending`, `test_has_ended`.
- IDLE/DONE with `arm`: go to ARMED. Clear `words_sent`, `drop_cnt` and the buffer.
- ARMED with `trig_start`: go to CAPTURE. A `frame_valid` in the same cycle is captured into slot 0.
- CAPTURE packing:
  - A frame is written into slot `dct_count`, then `dct_count` increments.
  - When `dct_count` reaches 3, `out_valid` rises.
- While `out_valid=1`:
  - With `out_ready=0`: the buffer is frozen and any frame is dropped (`drop_cnt`+1).
  - With `out_ready=1`: the handshake completes and `words_sent` increments. A same-cycle frame goes to slot 0 with `dct_count=1`. Otherwise the buffer clears and `dct_count=0`.
- CAPTURE with `trig_stop`: a same-cycle frame is still packed first, then the state goes to FLUSH.
- FLUSH:
  - If `dct_count>0` and `out_valid=0`, assert `out_valid` with the partial word.
  - On the final handshake, or immediately if `dct_count=0`, go to DONE.
  - Frames arriving in FLUSH are dropped and counted.
- Auto-end: a handshake that makes `words_sent==MAX_WORDS` goes directly to DONE. A same-cycle frame is dropped and counted. The buffer is cleared.
- DONE: hold `words_sent` and `drop_cnt`; `out_valid=0`.
- `disarm` in any state: next cycle IDLE, buffer and `dct_count` cleared, `out_valid=0`, and any pending word is discarded. The counters hold until the next `arm`.
- Async reset mid-capture: immediate return to the reset values; no partial word is emitted.

## Timing
- Registered outputs only; there is no combinational path from inputs to outputs.
- Frame-to-`dct_count` latency: 1 cycle.
- The third frame at edge N gives `out_valid=1` after edge N.
- `out_valid` and `dct_buffer` stay stable until a handshake or `disarm`.
- Sustained throughput is 1 frame/cycle when `out_ready` is held high.
- `test_ending` and `test_has_ended` follow the state register, 1 cycle after the transition.

## Structure
- A shared package `oci_dct_pkg` holds the state enum, `FRAME_W`, `FRAMES_PER_WORD`, and the `dct_buffer`/`dct_count` width constants. The OCI test bench imports it.
- Optional sub-module `oci_dct_packer`: slot write, count and handshake logic. The top level keeps the FSM and counters.

## Test plan
- Arm, start, then 3 frames 0x001/0x002/0x003 with `out_ready=1` → `dct_buffer`=0x00300801, `dct_count`=3, one handshake, `words_sent`=1.
- Hold `out_ready=0` after a full word, then send 2 frames → `drop_cnt`=2 and the buffer stays unchanged. Raising `out_ready` together with frame 0x0AA → slot0=0x0AA, `dct_count`=1.
- Capture 4 frames, then `trig_stop` → partial word with `dct_count`=1 and upper slots zero. `test_ending` is high during FLUSH. After the handshake `test_has_ended`=1.
- 48 frames back-to-back with `out_ready=1` and `MAX_WORDS`=16 → DONE after the 16th handshake. A frame in the same cycle gives `drop_cnt`=1.
- `disarm` while `out_valid=1` → next cycle IDLE, `out_valid`=0, `dct_count`=0. A subsequent `arm` clears `words_sent`.
- Assert `reset_n` low mid-CAPTURE, asynchronously between edges → all outputs 0 immediately, and state IDLE after release.
